// File: rtl/dht_pkg.sv
// Shared DHT11 definitions: FSM encoding, default timing and frame layout.
package dht_pkg;

    // Sensor-side protocol states, in transmission order.
    typedef enum logic [2:0] {
        StIdle,
        StHostLow,
        StRespDly,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StEndLow
    } dht_state_e;

    // Four data bytes plus checksum.
    localparam int unsigned FRAME_BITS = 40;

    // Default timing, in microseconds unless noted.
    localparam int unsigned DEF_CLK_PER_US   = 12;
    localparam int unsigned DEF_START_MIN_US = 18000;
    localparam int unsigned DEF_RESP_DLY_US  = 30;
    localparam int unsigned DEF_RESP_LOW_US  = 80;
    localparam int unsigned DEF_RESP_HIGH_US = 80;
    localparam int unsigned DEF_BIT_LOW_US   = 50;
    localparam int unsigned DEF_BIT0_HIGH_US = 27;
    localparam int unsigned DEF_BIT1_HIGH_US = 70;

    // Checksum byte: sum of the four data bytes, wrapping at 256.
    function automatic logic [7:0] dht_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
        logic [7:0] sum;
        sum = a + b + c + d;
        return sum;
    endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Free-running divider producing a one-clock strobe every CLK_PER_US clocks.
module dht_us_tick
    import dht_pkg::*;
#(
    parameter int unsigned CLK_PER_US = DEF_CLK_PER_US
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_US - 1);

    logic [DIV_W-1:0] div_q, div_d;

    // Wrap the divider at CLK_PER_US-1.
    always_comb begin
        div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    end

    // Divider register; restarts at zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_MAX);

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on DQ and answers with the
// handshake, 40 data bits MSB first and a closing end-low.
module dht11_responder
    import dht_pkg::*;
#(
    parameter int unsigned CLK_PER_US   = DEF_CLK_PER_US,
    parameter int unsigned START_MIN_US = DEF_START_MIN_US,
    parameter int unsigned RESP_DLY_US  = DEF_RESP_DLY_US,
    parameter int unsigned RESP_LOW_US  = DEF_RESP_LOW_US,
    parameter int unsigned RESP_HIGH_US = DEF_RESP_HIGH_US,
    parameter int unsigned BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int unsigned BIT0_HIGH_US = DEF_BIT0_HIGH_US,
    parameter int unsigned BIT1_HIGH_US = DEF_BIT1_HIGH_US
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = $clog2(START_MIN_US + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] START_MIN = CNT_W'(START_MIN_US);
    localparam logic [CNT_W-1:0] RESP_DLY  = CNT_W'(RESP_DLY_US);
    localparam logic [CNT_W-1:0] RESP_LOW  = CNT_W'(RESP_LOW_US);
    localparam logic [CNT_W-1:0] RESP_HIGH = CNT_W'(RESP_HIGH_US);
    localparam logic [CNT_W-1:0] BIT_LOW   = CNT_W'(BIT_LOW_US);
    localparam logic [CNT_W-1:0] BIT0_HIGH = CNT_W'(BIT0_HIGH_US);
    localparam logic [CNT_W-1:0] BIT1_HIGH = CNT_W'(BIT1_HIGH_US);
    localparam logic [5:0]       LAST_IDX  = 6'(FRAME_BITS - 1);

    dht_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [5:0]            idx_q, idx_d;
    logic                  dq_meta_q, dq_sync_q;
    logic                  dq_oe_q, dq_oe_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  tick;

    dht_us_tick #(
        .CLK_PER_US(CLK_PER_US)
    ) u_us_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Two-flop synchronizer for the raw pin; resets to the idle (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_meta_q <= 1'b1;
            dq_sync_q <= 1'b1;
        end else begin
            dq_meta_q <= dq_in;
            dq_sync_q <= dq_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the line is only watched in StIdle and StHostLow.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!dq_sync_q) state_d = StHostLow;
            StHostLow:  if (dq_sync_q) state_d = (cnt_q >= START_MIN) ? StRespDly : StIdle;
            StRespDly:  if (cnt_q == RESP_DLY) state_d = StRespLow;
            StRespLow:  if (cnt_q == RESP_LOW) state_d = StRespHigh;
            StRespHigh: if (cnt_q == RESP_HIGH) state_d = StBitLow;
            StBitLow:   if (cnt_q == BIT_LOW) state_d = StBitHigh;
            StBitHigh: begin
                if (cnt_q == (sr_q[FRAME_BITS-1] ? BIT1_HIGH : BIT0_HIGH)) begin
                    state_d = (idx_q == '0) ? StEndLow : StBitLow;
                end
            end
            StEndLow:   if (cnt_q == BIT_LOW) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Datapath next state: us counter, frame latch/shift and bit index.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        idx_d = idx_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((state_q == StHostLow) && (state_d == StRespDly)) begin
            sr_d = {hum_int, hum_dec, tmp_int, tmp_dec,
                    dht_checksum(hum_int, hum_dec, tmp_int, tmp_dec)};
        end
        if ((state_q == StRespHigh) && (state_d == StBitLow)) begin
            idx_d = LAST_IDX;
        end
        if ((state_q == StBitHigh) && (state_d != StBitHigh)) begin
            sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
            idx_d = (idx_q == '0) ? idx_q : idx_q - 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    // Output decode from the upcoming state so the registered outputs align with it.
    always_comb begin
        dq_oe_d      = state_d inside {StRespLow, StBitLow, StEndLow};
        busy_d       = !(state_d inside {StIdle, StHostLow});
        frame_done_d = (state_q == StEndLow) && (state_d == StIdle);
    end

    // Registered outputs keep DQ glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_oe_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            dq_oe_q      <= dq_oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dq_oe      = dq_oe_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder with shortened protocol timing.
module tb_dht11_responder;

    localparam int CPU   = 3;
    localparam int START = 100;
    localparam int DLY   = 6;
    localparam int RL    = 16;
    localparam int RH    = 16;
    localparam int BL    = 10;
    localparam int B0    = 5;
    localparam int B1    = 14;
    localparam int LIMIT = 300 * CPU;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] hd;
        logic [7:0] ti;
        logic [7:0] td;
        logic [7:0] chk;
        int         low_us;
        bit         answer;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hum_int = '0;
    logic [7:0] hum_dec = '0;
    logic [7:0] tmp_int = '0;
    logic [7:0] tmp_dec = '0;
    logic       host_low = 1'b0;
    logic       dq_in;
    logic       dq_oe;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_count = 0;
    logic [39:0] exp_q[$];
    vec_t vecs[6];

    // Open-drain wire: low when either side pulls.
    assign dq_in = ~(dq_oe | host_low);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_count <= fd_count + 1;
    end

    dht11_responder #(
        .CLK_PER_US  (CPU),
        .START_MIN_US(START),
        .RESP_DLY_US (DLY),
        .RESP_LOW_US (RL),
        .RESP_HIGH_US(RH),
        .BIT_LOW_US  (BL),
        .BIT0_HIGH_US(B0),
        .BIT1_HIGH_US(B1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hum_int   (hum_int),
        .hum_dec   (hum_dec),
        .tmp_int   (tmp_int),
        .tmp_dec   (tmp_dec),
        .dq_in     (dq_in),
        .dq_oe     (dq_oe),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d clk expected %0d..%0d clk", name, act, lo, hi);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for dq_oe edge", name);
    endtask

    // Nominal n us with +/-1 us tolerance, in clocks.
    function automatic bit in_us(input int w, input int n);
        return (w >= (n - 1) * CPU) && (w <= (n + 1) * CPU);
    endfunction

    // Count negedges while dq_oe holds the given level.
    task automatic measure(input logic level, input string name, output int w, output bit ok);
        w  = 0;
        ok = 1'b1;
        while (dq_oe === level) begin
            if (w >= LIMIT) begin
                fail_now(name);
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            w++;
        end
    endtask

    task automatic host_start(input int low_us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_us * CPU) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic set_data(input logic [7:0] a, b, c, d);
        hum_int = a;
        hum_dec = b;
        tmp_int = c;
        tmp_dec = d;
    endtask

    // Check that the DUT stays silent for a number of clocks.
    task automatic quiet(input string name, input int clocks);
        int act = 0;
        int fd0 = fd_count;
        repeat (clocks) begin
            @(negedge clk);
            if (dq_oe !== 1'b0 || busy !== 1'b0) act++;
        end
        check({name, " activity"}, 64'(act), 64'd0);
        check({name, " frame_done"}, 64'(fd_count - fd0), 64'd0);
    endtask

    // Decode one frame from dq_oe and compare it against the scoreboard head.
    task automatic capture_frame(input string tag);
        int          w;
        bit          ok;
        int          bad = 0;
        int          fd0 = fd_count;
        logic [39:0] exp;
        logic [39:0] got = '0;
        if (exp_q.size() == 0) begin
            fail_now({tag, " scoreboard empty"});
            return;
        end
        exp = exp_q.pop_front();
        measure(1'b0, {tag, " resp_dly"}, w, ok);
        if (!ok) return;
        check_range({tag, " resp_dly"}, w, (DLY - 1) * CPU, (DLY + 2) * CPU);
        check({tag, " busy in frame"}, 64'(busy), 64'd1);
        measure(1'b1, {tag, " resp_low"}, w, ok);
        if (!ok) return;
        check_range({tag, " resp_low"}, w, (RL - 1) * CPU, (RL + 1) * CPU);
        measure(1'b0, {tag, " resp_high"}, w, ok);
        if (!ok) return;
        check_range({tag, " resp_high"}, w, (RH - 1) * CPU, (RH + 1) * CPU);
        for (int i = 0; i < 40; i++) begin
            measure(1'b1, {tag, " bit_low"}, w, ok);
            if (!ok) return;
            if (!in_us(w, BL)) bad++;
            measure(1'b0, {tag, " bit_high"}, w, ok);
            if (!ok) return;
            got = {got[38:0], (w > ((B0 + B1) * CPU) / 2)};
            if (!in_us(w, exp[39-i] ? B1 : B0)) bad++;
        end
        check({tag, " bit widths out of range"}, 64'(bad), 64'd0);
        measure(1'b1, {tag, " end_low"}, w, ok);
        if (!ok) return;
        check_range({tag, " end_low"}, w, (BL - 1) * CPU, (BL + 1) * CPU);
        repeat (2) @(negedge clk);
        check({tag, " frame_done pulses"}, 64'(fd_count - fd0), 64'd1);
        check({tag, " busy after frame"}, 64'(busy), 64'd0);
        check({tag, " frame data"}, 64'(got), 64'(exp));
    endtask

    initial begin
        int  w;
        bit  ok;
        vecs[0] = '{8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 120, 1'b1};
        vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 30,  1'b0};
        vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h14, 110, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 90,  1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 150, 1'b1};
        vecs[5] = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 200, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset dq_oe", 64'(dq_oe), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven frames and rejected short pulses.
        for (int v = 0; v < 6; v++) begin
            set_data(vecs[v].hi, vecs[v].hd, vecs[v].ti, vecs[v].td);
            if (vecs[v].answer) begin
                exp_q.push_back({vecs[v].hi, vecs[v].hd, vecs[v].ti, vecs[v].td, vecs[v].chk});
            end
            host_start(vecs[v].low_us);
            if (vecs[v].answer) begin
                capture_frame($sformatf("vec%0d", v));
            end else begin
                quiet($sformatf("vec%0d short pulse", v), (DLY + RL + 20) * CPU);
            end
            repeat (20) @(negedge clk);
        end

        // Reset during a bit low releases DQ at once and leaves the block idle.
        set_data(8'hC3, 8'h3C, 8'h81, 8'h18);
        host_start(120);
        measure(1'b0, "rst resp_dly", w, ok);
        if (ok) measure(1'b1, "rst resp_low", w, ok);
        if (ok) measure(1'b0, "rst resp_high", w, ok);
        for (int i = 0; i < 19 && ok; i++) begin
            measure(1'b1, "rst bit_low", w, ok);
            if (ok) measure(1'b0, "rst bit_high", w, ok);
        end
        repeat (4) @(negedge clk);
        check("rst dq_oe before reset", 64'(dq_oe), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst dq_oe async", 64'(dq_oe), 64'd0);
        check("rst busy async", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        quiet("after mid-frame reset", 400 * CPU);

        // Data change and host pulse mid-frame do not disturb the latched frame.
        set_data(8'h42, 8'h07, 8'h1E, 8'h09);
        exp_q.push_back({8'h42, 8'h07, 8'h1E, 8'h09, 8'h70});
        host_start(130);
        fork
            begin
                repeat (250 * CPU) @(negedge clk);
                set_data(8'h99, 8'h88, 8'h77, 8'h66);
                host_low = 1'b1;
                repeat (120 * CPU) @(negedge clk);
                host_low = 1'b0;
            end
        join_none
        capture_frame("midframe");
        quiet("midframe no restart", 400 * CPU);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

endmodule
